tcm_dec_trb_ctrl: RTL and testbench

TCM_DEC_TRB_CTRL -- requirements
Module: tcm_dec_trb_ctrl

---
 rtl/tcm_dec_trb_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_tcm_dec_trb_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_dec_trb_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tcm_dec_trb_ctrl
// Brief    : TCM decoder traceback controller. Stores survivor-decision frames
//            in two ping-pong memory banks and replays each frame backwards
//            (last address down to 0) with a read-latency-aligned strobe set.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tcm_dec_trb_ctrl #(
   parameter int pADDR_W  = 10,
   parameter int pSTATE_W = 6,
   parameter int pRD_LAT  = 2
) (
   input  logic                iclk,
   input  logic                ireset_n,
   input  logic                iclkena,
   input  logic                isop,
   input  logic                ival,
   input  logic                ieop,
   input  logic [pSTATE_W-1:0] istate_best,
   output logic                ordy,
   output logic                owena,
   output logic [pADDR_W:0]    owaddr,
   output logic                orena,
   output logic [pADDR_W:0]    oraddr,
   output logic                otrb_sop,
   output logic                otrb_val,
   output logic                otrb_eop,
   output logic [pSTATE_W-1:0] otrb_state,
   output logic                obusy,
   output logic                oerr
);

   localparam logic [pADDR_W-1:0] c_ADDR_MAX   = '1;
   localparam logic [pADDR_W-1:0] c_ADDR_ONE   = pADDR_W'(1);
   localparam logic [2:0]         c_DRAIN_LAST = 3'(pRD_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_TRACE = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   // write side
   logic                r_wbank;
   logic [pADDR_W-1:0]  r_wptr;
   logic                r_in_frame;
   logic                r_ovf;
   logic                r_err;
   logic [1:0]          r_full;
   logic [pADDR_W-1:0]  r_len  [0:1];
   logic [pSTATE_W-1:0] r_best [0:1];

   // read side
   state_t              r_state;
   logic                r_rbank;
   logic [pADDR_W-1:0]  r_rptr;
   logic                r_first;
   logic [2:0]          r_drain_cnt;
   logic [pSTATE_W-1:0] r_trb_state;
   logic [pRD_LAT-1:0]  r_dl_val;
   logic [pRD_LAT-1:0]  r_dl_sop;
   logic [pRD_LAT-1:0]  r_dl_eop;

   logic                w_wr_try;
   logic                w_wr_acc;
   logic                w_drop;
   logic                w_restart;
   logic                w_wr_en;
   logic                w_close;
   logic                w_ovf_hit;
   logic [pADDR_W-1:0]  w_waddr;
   logic [pADDR_W-1:0]  w_last_len;
   logic                w_rd_last;
   logic                w_rd_clr;
   logic [1:0]          w_full_set;
   logic [1:0]          w_full_clr;

   // Write qualification. Reset gates acceptance so no write strobe escapes
   // while ireset_n is low.
   assign ordy       = ~r_full[r_wbank];
   assign w_wr_try   = ireset_n & iclkena & ival & ordy;
   assign w_wr_acc   = w_wr_try & (isop | r_in_frame);
   assign w_drop     = w_wr_try & ~isop & ~r_in_frame;
   assign w_restart  = w_wr_acc & isop & r_in_frame;
   assign w_waddr    = isop ? '0 : r_wptr;
   // After an overflow the rest of the frame is swallowed, but a new isop
   // always restarts a clean frame.
   assign w_wr_en    = w_wr_acc & (isop | ~r_ovf);
   assign w_close    = w_wr_acc & ieop;
   assign w_ovf_hit  = w_wr_en & ~ieop & (w_waddr == c_ADDR_MAX);
   assign w_last_len = (r_ovf & ~isop) ? c_ADDR_MAX : w_waddr;

   assign owena  = w_wr_en;
   assign owaddr = {r_wbank, w_waddr};

   // Read strobes are a decode of the registered FSM state and pointer.
   assign orena      = (r_state == S_TRACE);
   assign oraddr     = {r_rbank, r_rptr};
   assign w_rd_last  = orena & (r_rptr == '0);
   assign w_rd_clr   = iclkena & w_rd_last;

   assign w_full_set = w_close  ? (r_wbank ? 2'b10 : 2'b01) : 2'b00;
   assign w_full_clr = w_rd_clr ? (r_rbank ? 2'b10 : 2'b01) : 2'b00;

   assign otrb_val   = r_dl_val[pRD_LAT-1];
   assign otrb_sop   = r_dl_sop[pRD_LAT-1];
   assign otrb_eop   = r_dl_eop[pRD_LAT-1];
   assign otrb_state = r_trb_state;
   assign obusy      = (r_state != S_IDLE);
   assign oerr       = r_err;

   // Write pointer, frame tracking, per-bank length/best capture, sticky error.
   always_ff @(posedge iclk or negedge ireset_n) begin
      if (!ireset_n) begin
         r_wbank    <= 1'b0;
         r_wptr     <= '0;
         r_in_frame <= 1'b0;
         r_ovf      <= 1'b0;
         r_err      <= 1'b0;
         r_len[0]   <= '0;
         r_len[1]   <= '0;
         r_best[0]  <= '0;
         r_best[1]  <= '0;
      end else if (iclkena) begin
         if (w_drop | w_restart | w_ovf_hit)
            r_err <= 1'b1;
         if (w_wr_acc) begin
            if (w_close) begin
               r_len[r_wbank]  <= w_last_len;
               r_best[r_wbank] <= istate_best;
               r_wbank         <= ~r_wbank;
               r_wptr          <= '0;
               r_in_frame      <= 1'b0;
               r_ovf           <= 1'b0;
            end else begin
               r_in_frame <= 1'b1;
               if (w_wr_en)
                  r_wptr <= w_waddr + c_ADDR_ONE;
               if (w_ovf_hit)
                  r_ovf <= 1'b1;
               else if (isop)
                  r_ovf <= 1'b0;
            end
         end
      end
   end

   // Bank full flags: the write side's set wins over a same-bank read clear.
   always_ff @(posedge iclk or negedge ireset_n) begin
      if (!ireset_n)
         r_full <= 2'b00;
      else if (iclkena)
         r_full <= (r_full & ~w_full_clr) | w_full_set;
   end

   // Read FSM: pick up a full bank, trace it backwards, then let the read
   // pipeline empty before the traceback state may change.
   always_ff @(posedge iclk or negedge ireset_n) begin
      if (!ireset_n) begin
         r_state     <= S_IDLE;
         r_rbank     <= 1'b0;
         r_rptr      <= '0;
         r_first     <= 1'b0;
         r_drain_cnt <= '0;
         r_trb_state <= '0;
      end else if (iclkena) begin
         case (r_state)
            S_IDLE: begin
               if (r_full[r_rbank]) begin
                  r_state     <= S_TRACE;
                  r_rptr      <= r_len[r_rbank];
                  r_trb_state <= r_best[r_rbank];
                  r_first     <= 1'b1;
               end
            end
            S_TRACE: begin
               r_first <= 1'b0;
               if (r_rptr == '0) begin
                  r_rbank     <= ~r_rbank;
                  r_state     <= S_DRAIN;
                  r_drain_cnt <= '0;
               end else begin
                  r_rptr <= r_rptr - c_ADDR_ONE;
               end
            end
            S_DRAIN: begin
               if (r_drain_cnt == c_DRAIN_LAST)
                  r_state <= S_IDLE;
               else
                  r_drain_cnt <= r_drain_cnt + 3'd1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Delay line aligning val/sop/eop with the decision-memory read data.
   always_ff @(posedge iclk or negedge ireset_n) begin
      if (!ireset_n) begin
         r_dl_val <= '0;
         r_dl_sop <= '0;
         r_dl_eop <= '0;
      end else if (iclkena) begin
         r_dl_val[0] <= orena;
         r_dl_sop[0] <= orena & r_first;
         r_dl_eop[0] <= w_rd_last;
         for (int i = 1; i < pRD_LAT; i++) begin
            r_dl_val[i] <= r_dl_val[i-1];
            r_dl_sop[i] <= r_dl_sop[i-1];
            r_dl_eop[i] <= r_dl_eop[i-1];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tcm_dec_trb_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_tcm_dec_trb_ctrl
// Brief    : Scoreboard testbench for tcm_dec_trb_ctrl. Expected write
//            addresses, read addresses and traceback strobes are queued when
//            stimulus is driven and compared as the DUT produces them.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_tcm_dec_trb_ctrl;

   localparam int AW = 10;
   localparam int SW = 6;
   localparam logic [AW-1:0] MAXA = '1;

   logic          iclk = 1'b0;
   logic          ireset_n = 1'b0;
   logic          iclkena = 1'b1;
   logic          isop = 1'b0, ival = 1'b0, ieop = 1'b0;
   logic [SW-1:0] istate_best = '0;
   logic          ordy, owena, orena, otrb_sop, otrb_val, otrb_eop, obusy, oerr;
   logic [AW:0]   owaddr, oraddr;
   logic [SW-1:0] otrb_state;

   tcm_dec_trb_ctrl #(.pADDR_W(AW), .pSTATE_W(SW), .pRD_LAT(2)) dut (
      .iclk(iclk), .ireset_n(ireset_n), .iclkena(iclkena),
      .isop(isop), .ival(ival), .ieop(ieop), .istate_best(istate_best),
      .ordy(ordy), .owena(owena), .owaddr(owaddr),
      .orena(orena), .oraddr(oraddr),
      .otrb_sop(otrb_sop), .otrb_val(otrb_val), .otrb_eop(otrb_eop),
      .otrb_state(otrb_state), .obusy(obusy), .oerr(oerr)
   );

   always #5 iclk = ~iclk;

   int total = 0;
   int bad   = 0;

   logic [AW:0] wq[$];
   logic [AW:0] rq[$];
   logic [7:0]  tq[$];   // {sop, eop, state}

   // reference model of the write side
   logic          m_wbank, m_in_frame, m_ovf, m_err;
   logic [AW-1:0] m_wptr;
   logic          g_stall;

   // scoreboard monitor, sampled mid-cycle
   always @(negedge iclk) begin
      if (ireset_n) begin
         if (owena) begin
            total++;
            if (wq.size() == 0) begin
               bad++; $display("FAIL wr_addr unexpected write: got=%h required=none", owaddr);
            end else begin
               logic [AW:0] e; e = wq.pop_front();
               if (owaddr !== e) begin
                  bad++; $display("FAIL wr_addr: got=%h required=%h", owaddr, e);
               end
            end
         end
         if (iclkena && orena) begin
            total++;
            if (rq.size() == 0) begin
               bad++; $display("FAIL rd_addr unexpected read: got=%h required=none", oraddr);
            end else begin
               logic [AW:0] e; e = rq.pop_front();
               if (oraddr !== e) begin
                  bad++; $display("FAIL rd_addr: got=%h required=%h", oraddr, e);
               end
            end
         end
         if (iclkena && otrb_val) begin
            total++;
            if (tq.size() == 0) begin
               bad++; $display("FAIL trb unexpected val: sop=%b eop=%b", otrb_sop, otrb_eop);
            end else begin
               logic [7:0] e; e = tq.pop_front();
               if ({otrb_sop, otrb_eop, otrb_state} !== e) begin
                  bad++; $display("FAIL trb: got sop=%b eop=%b st=%0d required sop=%b eop=%b st=%0d",
                                  otrb_sop, otrb_eop, otrb_state, e[7], e[6], e[5:0]);
               end
            end
         end else if (iclkena && (otrb_sop || otrb_eop)) begin
            total++; bad++;
            $display("FAIL trb strobe without val: sop=%b eop=%b required 0", otrb_sop, otrb_eop);
         end
      end
   end

   task automatic model_clear();
      wq.delete(); rq.delete(); tq.delete();
      m_wbank = 1'b0; m_in_frame = 1'b0; m_ovf = 1'b0; m_err = 1'b0; m_wptr = '0;
   endtask

   task automatic do_reset();
      ireset_n = 1'b0; ival = 1'b0; isop = 1'b0; ieop = 1'b0; iclkena = 1'b1;
      model_clear();
      repeat (2) @(posedge iclk);
      #1 ireset_n = 1'b1;
      @(posedge iclk); #1;
   endtask

   // Drive one word (waiting for ordy) and queue what the DUT must do with it.
   task automatic send_word(input logic sop, input logic eop, input logic [SW-1:0] best);
      int n;
      logic [AW-1:0] a, len;
      n = 0;
      while (!ordy && n < 200) begin
         g_stall = 1'b1;
         @(posedge iclk); #1; n++;
      end
      if (!ordy) begin
         total++; bad++;
         $display("FAIL send_word ordy timeout: ordy=%b required=1", ordy);
         ival = 1'b0;
         return;
      end
      ival = 1'b1; isop = sop; ieop = eop; istate_best = best;
      if (!sop && !m_in_frame) begin
         m_err = 1'b1;
      end else begin
         a = sop ? '0 : m_wptr;
         if (sop && m_in_frame) m_err = 1'b1;
         if (sop) m_ovf = 1'b0;
         if (sop || !m_ovf) wq.push_back({m_wbank, a});
         m_wptr = a + 1'b1;
         m_in_frame = 1'b1;
         if (eop) begin
            len = (m_ovf && !sop) ? MAXA : a;
            for (int i = int'(len); i >= 0; i--) begin
               rq.push_back({m_wbank, AW'(i)});
               tq.push_back({(i == int'(len)), (i == 0), best});
            end
            m_wbank = ~m_wbank; m_wptr = '0; m_in_frame = 1'b0; m_ovf = 1'b0;
         end else if (!m_ovf && a == MAXA) begin
            m_ovf = 1'b1; m_err = 1'b1;
         end
      end
      @(posedge iclk); #1;
   endtask

   task automatic send_frame(input int nw, input logic [SW-1:0] best);
      for (int k = 0; k < nw; k++)
         send_word(k == 0, k == nw - 1, best);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      ival = 1'b0;
      while ((rq.size() != 0 || tq.size() != 0 || obusy || otrb_val) && n < 3000) begin
         @(posedge iclk); #1; n++;
      end
      total++;
      if (n >= 3000) begin
         bad++; $display("FAIL drain timeout: pending_rd=%0d pending_trb=%0d required 0", rq.size(), tq.size());
      end
   endtask

   task automatic test_reset();
      ireset_n = 1'b0; ival = 1'b1; isop = 1'b1; ieop = 1'b0;
      model_clear();
      repeat (2) @(posedge iclk);
      #1;
      total++; if (ordy !== 1'b1) begin bad++; $display("FAIL reset ordy: got=%b required=1", ordy); end
      total++; if (owena !== 1'b0) begin bad++; $display("FAIL reset owena: got=%b required=0", owena); end
      total++; if (owaddr !== '0) begin bad++; $display("FAIL reset owaddr: got=%h required=0", owaddr); end
      total++; if ({orena, obusy, oerr} !== 3'b000) begin bad++; $display("FAIL reset rd/busy/err: got=%b required=000", {orena, obusy, oerr}); end
      total++; if ({otrb_val, otrb_sop, otrb_eop} !== 3'b000) begin bad++; $display("FAIL reset trb strobes: got=%b required=000", {otrb_val, otrb_sop, otrb_eop}); end
      total++; if (oraddr !== '0 || otrb_state !== '0) begin bad++; $display("FAIL reset raddr/state: got=%h/%0d required=0/0", oraddr, otrb_state); end
      ival = 1'b0; isop = 1'b0;
      ireset_n = 1'b1;
      @(posedge iclk); #1;
   endtask

   task automatic test_basic();
      do_reset();
      send_frame(5, 6'd17);
      ival = 1'b0;
      total++; if (orena !== 1'b0) begin bad++; $display("FAIL basic early orena: got=%b required=0", orena); end
      @(posedge iclk); #1;
      total++; if (orena !== 1'b1 || oraddr !== {1'b0, 10'd4}) begin bad++; $display("FAIL basic first read: got=%b/%h required=1/004", orena, oraddr); end
      repeat (2) @(posedge iclk); #1;
      total++; if (otrb_sop !== 1'b1 || otrb_state !== 6'd17) begin bad++; $display("FAIL basic sop latency: got=%b/%0d required=1/17", otrb_sop, otrb_state); end
      wait_drain();
      total++; if (oerr !== 1'b0) begin bad++; $display("FAIL basic oerr: got=%b required=0", oerr); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      g_stall = 1'b0;
      send_frame(8, 6'd3);
      send_frame(8, 6'd44);
      send_frame(8, 6'd63);
      wait_drain();
      total++; if (g_stall !== 1'b1) begin bad++; $display("FAIL b2b ordy stall: got=%b required=1", g_stall); end
      total++; if (oerr !== 1'b0) begin bad++; $display("FAIL b2b oerr: got=%b required=0", oerr); end
   endtask

   task automatic test_single();
      do_reset();
      send_word(1'b1, 1'b1, 6'd5);
      ival = 1'b0;
      repeat (3) @(posedge iclk); #1;
      total++; if ({otrb_val, otrb_sop, otrb_eop} !== 3'b111) begin bad++; $display("FAIL single strobes: got=%b required=111", {otrb_val, otrb_sop, otrb_eop}); end
      @(posedge iclk); #1;
      total++; if (otrb_val !== 1'b0) begin bad++; $display("FAIL single val width: got=%b required=0", otrb_val); end
      wait_drain();
   endtask

   task automatic test_protocol_err();
      do_reset();
      send_word(1'b0, 1'b0, 6'd0);
      ival = 1'b0;
      total++; if (oerr !== 1'b1) begin bad++; $display("FAIL proto drop oerr: got=%b required=1", oerr); end
      for (int k = 0; k < 3; k++) send_word(k == 0, 1'b0, 6'd0);
      send_word(1'b1, 1'b0, 6'd0);
      send_word(1'b0, 1'b0, 6'd0);
      send_word(1'b0, 1'b1, 6'd9);
      wait_drain();
      total++; if (oerr !== 1'b1) begin bad++; $display("FAIL proto sticky oerr: got=%b required=1", oerr); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int k = 0; k < 1023; k++) send_word(k == 0, 1'b0, 6'd0);
      total++; if (oerr !== 1'b0) begin bad++; $display("FAIL ovf early oerr: got=%b required=0", oerr); end
      send_word(1'b0, 1'b0, 6'd0);
      total++; if (oerr !== 1'b1) begin bad++; $display("FAIL ovf oerr: got=%b required=1", oerr); end
      send_word(1'b0, 1'b1, 6'd21);
      wait_drain();
   endtask

   task automatic test_clkena_and_reset();
      do_reset();
      send_frame(8, 6'd12);
      ival = 1'b0;
      @(posedge iclk); #1;
      total++; if (oraddr !== {1'b0, 10'd7}) begin bad++; $display("FAIL ena first read: got=%h required=007", oraddr); end
      @(posedge iclk); #1;
      total++; if (oraddr !== {1'b0, 10'd6}) begin bad++; $display("FAIL ena second read: got=%h required=006", oraddr); end
      iclkena = 1'b0;
      repeat (3) begin
         @(posedge iclk); #1;
         total++; if (orena !== 1'b1 || oraddr !== {1'b0, 10'd6}) begin bad++; $display("FAIL ena freeze: got=%b/%h required=1/006", orena, oraddr); end
      end
      iclkena = 1'b1;
      @(posedge iclk); #1;
      total++; if (oraddr !== {1'b0, 10'd5}) begin bad++; $display("FAIL ena resume: got=%h required=005", oraddr); end
      wait_drain();
      // reset in the middle of a trace
      send_frame(8, 6'd30);
      ival = 1'b0;
      repeat (4) @(posedge iclk); #1;
      ireset_n = 1'b0;
      model_clear();
      #1;
      total++; if ({orena, obusy, otrb_val, oerr} !== 4'b0000 || ordy !== 1'b1) begin bad++; $display("FAIL midreset outputs: got=%b ordy=%b required=0000/1", {orena, obusy, otrb_val, oerr}, ordy); end
      total++; if (oraddr !== '0 || otrb_state !== '0) begin bad++; $display("FAIL midreset addr/state: got=%h/%0d required=0/0", oraddr, otrb_state); end
      repeat (2) @(posedge iclk); #1;
      ireset_n = 1'b1;
      @(posedge iclk); #1;
      send_frame(2, 6'd7);
      wait_drain();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      g_stall = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_single();
      test_protocol_err();
      test_overflow();
      test_clkena_and_reset();
      total++;
      if (wq.size() != 0) begin bad++; $display("FAIL leftover writes: got=%0d required=0", wq.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
